// File: rtl/tusca_pkg.sv
// tusca_pkg: shared state encoding and frame sizing for the TUSCA measurement path
package tusca_pkg;
  typedef enum logic [3:0] {
    INICIAL        = 4'd0,
    DISPARA        = 4'd1,
    ESPERA_BYTE    = 4'd2,
    ARMAZENA       = 4'd3,
    PUBLICA        = 4'd4,
    FALHA          = 4'd5,
    ESPERA_PERIODO = 4'd6
  } estado_t;
  localparam int N_BYTES_MEDIDA = 4;
  localparam int LARGURA_INDICE = $clog2(N_BYTES_MEDIDA);
endpackage

// File: rtl/sequenciador_medida_if.sv
// sequenciador_medida_if: start/UART-byte inputs and measurement outputs of the sequencer
// master drives start and the received-byte strobe; slave (the sequencer) drives the results
interface sequenciador_medida_if;
  logic start, rx_pronto, rx_paridade_ok;
  logic [7:0] rx_dado;
  logic medir_dht11, medida_valida, erro_medida, timeout_medida;
  logic [15:0] temperatura, umidade;
  logic [3:0] db_estado;
  modport master (
    output start, rx_pronto, rx_dado, rx_paridade_ok,
    input medir_dht11, temperatura, umidade, medida_valida, erro_medida, timeout_medida, db_estado
  );
  modport slave (
    input start, rx_pronto, rx_dado, rx_paridade_ok,
    output medir_dht11, temperatura, umidade, medida_valida, erro_medida, timeout_medida, db_estado
  );
endinterface

// File: rtl/contador_m.sv
// contador_m: modulo-M counter with synchronous clear, enable and terminal-count flag
// ports: clock, reset, clr (priority clear), en (count), fim (count == M-1)
module contador_m #(
  parameter int M = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic fim
);
  localparam int W = M > 1 ? $clog2(M) : 1;
  logic [W-1:0] q_q, q_d;
  assign fim = q_q == W'(M - 1);
  always_comb q_d = clr ? '0 : !en ? q_q : fim ? '0 : q_q + 1'b1;
  always_ff @(posedge clock) q_q <= reset ? '0 : q_d;
endmodule

// File: rtl/sequenciador_medida.sv
// sequenciador_medida: periodic DHT11 trigger and 4-byte reply assembly into temperature/humidity words
// ports: clock, reset (sync, active-high), s (slave side of sequenciador_medida_if)
// option: PARIDADE_EN defined aborts a frame on a byte with bad parity and reports erro_medida
module sequenciador_medida
  import tusca_pkg::*;
#(
  parameter int PERIODO_MEDIDA = 50_000_000,
  parameter int LARGURA_PULSO  = 1000,
  parameter int TIMEOUT_BYTE   = 2_000_000
) (
  input logic clock,
  input logic reset,
  sequenciador_medida_if.slave s
);
  estado_t estado_q, estado_d;
  logic [LARGURA_INDICE-1:0] indice_q, indice_d;
  logic [7:0] dado_q, dado_d;
  logic [7:0] sombra_q [N_BYTES_MEDIDA];
  logic [7:0] sombra_d [N_BYTES_MEDIDA];
  logic [15:0] temperatura_q, temperatura_d, umidade_q, umidade_d;
  logic medir_q, medir_d, valida_q, valida_d, erro_q, erro_d, timeout_q, timeout_d;
  logic expirou_q, expirou_d;
  logic fim_pulso, fim_timeout, fim_periodo, entra_dispara, byte_ruim;
`ifdef PARIDADE_EN
  assign byte_ruim = !s.rx_paridade_ok;
`else
  logic unused_paridade;
  assign unused_paridade = s.rx_paridade_ok;
  assign byte_ruim = 1'b0;
`endif
  assign entra_dispara = estado_d == DISPARA && estado_q != DISPARA;
  contador_m #(.M(LARGURA_PULSO)) u_pulso (
    .clock(clock), .reset(reset), .clr(estado_q != DISPARA), .en(estado_q == DISPARA), .fim(fim_pulso)
  );
  contador_m #(.M(TIMEOUT_BYTE)) u_timeout (
    .clock(clock), .reset(reset), .clr(estado_q != ESPERA_BYTE), .en(estado_q == ESPERA_BYTE), .fim(fim_timeout)
  );
  // the period runs across the whole frame; expirou remembers a wrap that happened before the frame ended
  contador_m #(.M(PERIODO_MEDIDA)) u_periodo (
    .clock(clock), .reset(reset), .clr(entra_dispara), .en(estado_q != INICIAL), .fim(fim_periodo)
  );
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      INICIAL:        estado_d = s.start ? DISPARA : INICIAL;
      DISPARA:        estado_d = fim_pulso ? ESPERA_BYTE : DISPARA;
      ESPERA_BYTE:    estado_d = s.rx_pronto ? (byte_ruim ? FALHA : ARMAZENA) : fim_timeout ? FALHA : ESPERA_BYTE;
      ARMAZENA:       estado_d = indice_q == LARGURA_INDICE'(N_BYTES_MEDIDA - 1) ? PUBLICA : ESPERA_BYTE;
      PUBLICA, FALHA: estado_d = ESPERA_PERIODO;
      ESPERA_PERIODO: estado_d = fim_periodo || expirou_q ? DISPARA : ESPERA_PERIODO;
      default:        estado_d = INICIAL;
    endcase
  end
  always_comb begin
    sombra_d = sombra_q;
    if (estado_q == ARMAZENA) sombra_d[indice_q] = dado_q;
    indice_d = entra_dispara ? '0 : estado_q == ARMAZENA ? indice_q + 1'b1 : indice_q;
    dado_d = estado_q == ESPERA_BYTE && s.rx_pronto ? s.rx_dado : dado_q;
    expirou_d = entra_dispara ? 1'b0 : fim_periodo && estado_q != INICIAL ? 1'b1 : expirou_q;
    // outputs are registered from the next state so they line up with the state they belong to
    temperatura_d = estado_d == PUBLICA ? {sombra_d[1], sombra_d[0]} : temperatura_q;
    umidade_d = estado_d == PUBLICA ? {sombra_d[3], sombra_d[2]} : umidade_q;
    medir_d = estado_d == DISPARA;
    valida_d = estado_d == PUBLICA;
    erro_d = entra_dispara ? 1'b0 : estado_q == ESPERA_BYTE && s.rx_pronto && byte_ruim ? 1'b1 : erro_q;
    timeout_d = entra_dispara ? 1'b0 : estado_q == ESPERA_BYTE && !s.rx_pronto && fim_timeout ? 1'b1 : timeout_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= INICIAL;
      indice_q <= '0;
      dado_q <= '0;
      sombra_q <= '{default: '0};
      temperatura_q <= '0;
      umidade_q <= '0;
      medir_q <= 1'b0;
      valida_q <= 1'b0;
      erro_q <= 1'b0;
      timeout_q <= 1'b0;
      expirou_q <= 1'b0;
    end else begin
      estado_q <= estado_d;
      indice_q <= indice_d;
      dado_q <= dado_d;
      sombra_q <= sombra_d;
      temperatura_q <= temperatura_d;
      umidade_q <= umidade_d;
      medir_q <= medir_d;
      valida_q <= valida_d;
      erro_q <= erro_d;
      timeout_q <= timeout_d;
      expirou_q <= expirou_d;
    end
  end
  assign s.medir_dht11 = medir_q;
  assign s.temperatura = temperatura_q;
  assign s.umidade = umidade_q;
  assign s.medida_valida = valida_q;
  assign s.erro_medida = erro_q;
  assign s.timeout_medida = timeout_q;
  assign s.db_estado = estado_q;
endmodule

// File: tb/tb_sequenciador_medida.sv
// tb_sequenciador_medida: directed/random frames checked against a frame-level model of the sequencer
`timescale 1ns/1ps
module tb_sequenciador_medida;
  localparam int P = 5000, L = 4, T = 2000;
`ifdef PARIDADE_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  logic clock = 1'b0, reset = 1'b1;
  always #5 clock = ~clock;
  sequenciador_medida_if vif();
  sequenciador_medida #(.PERIODO_MEDIDA(P), .LARGURA_PULSO(L), .TIMEOUT_BYTE(T)) dut (
    .clock(clock), .reset(reset), .s(vif)
  );
  int checks = 0, errors = 0, cyc = 0, n_valid = 0, exp_valid = 0, last_b = 0;
  logic [15:0] exp_t = '0, exp_u = '0;
  logic exp_err = 1'b0, exp_to = 1'b0;
  logic [7:0] fq[$];
  bit fp[$];
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) if (!reset && vif.medida_valida) n_valid <= n_valid + 1;
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end
  task automatic tick(int n = 1);
    repeat (n) begin @(posedge clock); #1; end
  endtask
  task automatic gap();
    tick($urandom_range(1, 8));
  endtask
  function automatic logic [7:0] rb();
    return 8'($urandom);
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send_byte(logic [7:0] d, bit ok);
    fq.push_back(d);
    fp.push_back(ok);
    last_b = cyc;
    vif.rx_dado = d;
    vif.rx_paridade_ok = ok;
    vif.rx_pronto = 1'b1;
    tick();
    vif.rx_pronto = 1'b0;
    vif.rx_paridade_ok = 1'b1;
  endtask
  // frame model: first bad-parity byte (if enabled) aborts, four good bytes publish, fewer time out
  task automatic model_frame();
    logic [7:0] b[4] = '{default: '0};
    int n = 0;
    bit bad = 1'b0;
    for (int i = 0; i < fq.size() && n < 4 && !bad; i++) begin
      if (PAR && !fp[i]) bad = 1'b1;
      else begin b[n] = fq[i]; n++; end
    end
    exp_err = bad;
    exp_to = !bad && n < 4;
    if (n == 4) begin
      exp_t = {b[1], b[0]};
      exp_u = {b[3], b[2]};
      exp_valid++;
    end
    fq.delete();
    fp.delete();
  endtask
  task automatic check_outputs(string tag);
    chk({tag, "_temp"}, vif.temperatura, exp_t);
    chk({tag, "_umid"}, vif.umidade, exp_u);
    chk({tag, "_erro"}, vif.erro_medida, exp_err);
    chk({tag, "_timeout"}, vif.timeout_medida, exp_to);
    chk({tag, "_n_valida"}, n_valid, exp_valid);
  endtask
  task automatic finish_good(string tag);
    chk({tag, "_valida_t1"}, vif.medida_valida, 0);
    tick();
    model_frame();
    chk({tag, "_valida_t2"}, vif.medida_valida, 1);
    chk({tag, "_temp_t2"}, vif.temperatura, exp_t);
    chk({tag, "_umid_t2"}, vif.umidade, exp_u);
    tick();
    chk({tag, "_valida_t3"}, vif.medida_valida, 0);
    check_outputs(tag);
  endtask
  task automatic wait_rise(string tag, output int c);
    int n = 0;
    while (vif.medir_dht11 !== 1'b1 && n < 2 * P) begin tick(); n++; end
    chk(tag, vif.medir_dht11, 1);
    c = cyc;
  endtask
  initial begin
    int r0, r1, r2, r3, r4, r5, r6, p;
    bit seen;
    vif.start = 1'b0;
    vif.rx_pronto = 1'b0;
    vif.rx_dado = '0;
    vif.rx_paridade_ok = 1'b1;
    tick(3);
    reset = 1'b0;
    tick();
    chk("rst_medir", vif.medir_dht11, 0);
    chk("rst_temp", vif.temperatura, 0);
    chk("rst_umid", vif.umidade, 0);
    chk("rst_valida", vif.medida_valida, 0);
    chk("rst_erro", vif.erro_medida, 0);
    chk("rst_timeout", vif.timeout_medida, 0);
    chk("rst_estado", vif.db_estado, 0);
    tick(20);
    chk("idle_no_trigger", vif.medir_dht11, 0);
    // normal frame
    vif.start = 1'b1;
    tick();
    vif.start = 1'b0;
    r0 = cyc;
    for (int i = 0; i < L; i++) begin chk("pulse_high", vif.medir_dht11, 1); tick(); end
    chk("pulse_low", vif.medir_dht11, 0);
    chk("estado_espera_byte", vif.db_estado, 2);
    send_byte(8'h02, 1'b1); gap();
    send_byte(8'h22, 1'b1); gap();
    send_byte(8'h34, 1'b1); gap();
    send_byte(8'h12, 1'b1);
    finish_good("frame_a");
    chk("frame_a_temp_2202", vif.temperatura, 16'h2202);
    chk("frame_a_umid_1234", vif.umidade, 16'h1234);
    // stray byte and start while waiting for the period
    tick(3);
    chk("estado_espera_periodo", vif.db_estado, 6);
    vif.rx_dado = 8'hAA;
    vif.rx_pronto = 1'b1;
    tick();
    vif.rx_pronto = 1'b0;
    vif.start = 1'b1;
    tick();
    vif.start = 1'b0;
    tick(5);
    chk("stray_estado", vif.db_estado, 6);
    check_outputs("stray");
    // silent frame: timeout and periodicity
    wait_rise("rise_b", r1);
    chk("periodo_ab", r1 - r0, P);
    tick(L);
    vif.start = 1'b1;
    tick();
    vif.start = 1'b0;
    chk("start_ignored_estado", vif.db_estado, 2);
    // timeout counter starts at r1+L and needs T cycles, then the flag registers one cycle later
    tick(r1 + L + T - 1 - cyc);
    chk("timeout_b_before", vif.timeout_medida, 0);
    tick();
    chk("timeout_b_at", vif.timeout_medida, 1);
    model_frame();
    tick(2);
    check_outputs("timeout_b");
    // partial frame: two bytes then silence
    wait_rise("rise_c", r2);
    chk("periodo_bc", r2 - r1, P);
    chk("timeout_cleared_c", vif.timeout_medida, 0);
    tick(L);
    send_byte(8'h02, 1'b1); gap();
    send_byte(8'h22, 1'b1);
    tick(last_b + T + 1 - cyc);
    chk("timeout_c_before", vif.timeout_medida, 0);
    tick();
    chk("timeout_c_at", vif.timeout_medida, 1);
    model_frame();
    tick(2);
    check_outputs("timeout_c");
    // random frame with one byte arriving on the timeout-expiry cycle
    wait_rise("rise_d", r3);
    chk("periodo_cd", r3 - r2, P);
    chk("timeout_cleared_d", vif.timeout_medida, 0);
    tick(L);
    send_byte(rb(), 1'b1);
    tick(last_b + T + 1 - cyc);
    send_byte(rb(), 1'b1);
    chk("expiry_byte_no_timeout", vif.timeout_medida, 0);
    gap();
    send_byte(rb(), 1'b1); gap();
    send_byte(rb(), 1'b1);
    finish_good("frame_d");
    // third byte with bad parity
    wait_rise("rise_e", r4);
    chk("periodo_de", r4 - r3, P);
    tick(L);
    send_byte(rb(), 1'b1); gap();
    send_byte(rb(), 1'b1); gap();
    send_byte(rb(), 1'b0);
    chk("erro_e", vif.erro_medida, 32'(PAR));
    tick(3);
    send_byte(rb(), 1'b1);
    model_frame();
    tick(4);
    check_outputs("frame_e");
    // every byte on its expiry cycle: frame outlasts the period, trigger follows right away
    wait_rise("rise_f", r5);
    chk("periodo_ef", r5 - r4, P);
    chk("erro_cleared_f", vif.erro_medida, 0);
    tick(L);
    tick(r5 + L + T - 1 - cyc);
    send_byte(rb(), 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(last_b + T + 1 - cyc);
      send_byte(rb(), 1'b1);
    end
    tick();
    p = cyc;
    model_frame();
    chk("frame_f_valida", vif.medida_valida, 1);
    chk("frame_f_temp", vif.temperatura, exp_t);
    chk("frame_f_umid", vif.umidade, exp_u);
    wait_rise("rise_late", r6);
    chk("late_trigger", (r6 - p >= 1 && r6 - p <= 2) ? 1 : 0, 1);
    // reset mid-frame
    tick(L);
    send_byte(rb(), 1'b1); gap();
    send_byte(rb(), 1'b1);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    fq.delete();
    fp.delete();
    exp_t = '0;
    exp_u = '0;
    exp_err = 1'b0;
    exp_to = 1'b0;
    tick();
    chk("midrst_estado", vif.db_estado, 0);
    chk("midrst_medir", vif.medir_dht11, 0);
    chk("midrst_valida", vif.medida_valida, 0);
    check_outputs("midrst");
    seen = 1'b0;
    for (int i = 0; i < P + 1000; i++) begin seen |= vif.medir_dht11; tick(); end
    chk("midrst_no_trigger", seen, 0);
    // restart after reset
    vif.start = 1'b1;
    tick();
    vif.start = 1'b0;
    chk("restart_medir", vif.medir_dht11, 1);
    tick(L);
    for (int i = 0; i < 4; i++) begin send_byte(rb(), 1'b1); gap(); end
    tick(T / 2);
    model_frame();
    check_outputs("restart");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
